// File: rtl/oram_bucket_server_pkg.sv
// Shared types, widths and helpers for the Path ORAM bucket server.
// Node numbering is 1-based heap order, so the storage address is n-1.
package oram_bucket_server_pkg;

  localparam int a = 8;
  localparam int d = 6;
  localparam int K = 3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int OFF_VAL = 0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_OUT,
    ST_WR_IN
  } state_e;

  // Tuple layout, MSB first: {valid, pos[D-2:0], bnum[D-1:0], val[8A-1:0]}
  function automatic int tuple_width(input int a_w, input int d_w);
    return 1 + (d_w - 1) + d_w + 8 * a_w;
  endfunction

  function automatic int off_bnum(input int a_w);
    return 8 * a_w;
  endfunction

  function automatic int off_pos(input int a_w, input int d_w);
    return 8 * a_w + d_w;
  endfunction

  function automatic int off_valid(input int a_w, input int d_w);
    return tuple_width(a_w, d_w) - 1;
  endfunction

  // Level l descends using leaf bit l-1, so leaf bits are consumed LSB first.
  function automatic int unsigned node_index(input int unsigned lvl, input logic [31:0] leaf);
    int unsigned n;
    n = 1;
    for (int unsigned i = 0; i < 31; i++) begin
      if (i < lvl) n = 2 * n + {31'b0, leaf[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/oram_bucket_server_ram.sv
// Single-port bucket store: synchronous write, registered read.
// Contents are not reset; the controller sweeps them clear after reset.
module oram_bucket_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/oram_bucket_server.sv
// Path ORAM storage responder: clears the tree after reset, then streams or
// stores one root-to-leaf path per command and flags path-invariant violations.
//   state     | meaning
//   INIT      | clearing one bucket per cycle
//   IDLE      | waiting for a command
//   RD_REQ    | RAM read of the current level in flight
//   RD_OUT    | bucket presented until the client takes it
//   WR_IN     | accepting the bucket for the current level
module oram_bucket_server #(
  parameter int A = oram_bucket_server_pkg::a,
  parameter int D = oram_bucket_server_pkg::d,
  parameter int K = oram_bucket_server_pkg::K
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   cmd_valid,
  output logic                                                   cmd_ready,
  input  logic                                                   cmd_op,
  input  logic [D-2:0]                                           cmd_leaf,
  output logic                                                   rd_valid,
  input  logic                                                   rd_ready,
  output logic [K*oram_bucket_server_pkg::tuple_width(A,D)-1:0]  rd_bucket,
  output logic [$clog2(D)-1:0]                                   rd_level,
  output logic                                                   rd_last,
  input  logic                                                   wr_valid,
  output logic                                                   wr_ready,
  input  logic [K*oram_bucket_server_pkg::tuple_width(A,D)-1:0]  wr_bucket,
  output logic                                                   busy,
  output logic                                                   err_path
);
  import oram_bucket_server_pkg::*;

  localparam int TW        = tuple_width(A, D);
  localparam int BW        = K * TW;
  localparam int NODES     = (1 << D) - 1;
  localparam int AW        = D;
  localparam int LW        = $clog2(D);
  localparam int OFF_POS   = off_pos(A, D);
  localparam int OFF_VALID = off_valid(A, D);

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [D-2:0]  leaf_q, leaf_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic          err_q, err_d;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr, node_addr;
  logic [BW-1:0] ram_wdata, ram_rdata;
  logic          last_lvl, bad_tuple;
  logic [D-2:0]  lvl_mask;

  assign node_addr = AW'(node_index(32'(level_q), 32'(leaf_q)) - 32'd1);
  assign last_lvl  = (level_q == LW'(D - 1));
  // Only the low `level` position bits must agree with the leaf; root is unconstrained.
  assign lvl_mask  = (D-1)'((32'd1 << level_q) - 32'd1);

  always_comb begin
    bad_tuple = 1'b0;
    for (int k = 0; k < K; k++) begin
      if (wr_bucket[k*TW + OFF_VALID] &&
          (((wr_bucket[k*TW + OFF_POS +: D-1] ^ leaf_q) & lvl_mask) != '0)) begin
        bad_tuple = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    leaf_d      = leaf_q;
    init_addr_d = init_addr_q;
    err_d       = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = node_addr;
    ram_wdata   = wr_bucket;
    cmd_ready   = 1'b0;
    rd_valid    = 1'b0;
    wr_ready    = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_we      = 1'b1;
        ram_addr    = init_addr_q;
        ram_wdata   = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == AW'(NODES - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          leaf_d  = cmd_leaf;
          level_d = '0;
          state_d = (cmd_op == OP_WRITE) ? ST_WR_IN : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        ram_re  = 1'b1;
        state_d = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (last_lvl) begin
            state_d = ST_IDLE;
          end else begin
            level_d = level_q + 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_IN: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_we = 1'b1;
          err_d  = bad_tuple;
          if (last_lvl) state_d = ST_IDLE;
          else          level_d = level_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      level_q     <= '0;
      leaf_q      <= '0;
      init_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      leaf_q      <= leaf_d;
      init_addr_q <= init_addr_d;
      err_q       <= err_d;
    end
  end

  // RAM output is unreset and only reloaded in RD_REQ, so gating keeps it stable and zero at reset.
  assign rd_bucket = rd_valid ? ram_rdata : '0;
  assign rd_level  = level_q;
  assign rd_last   = rd_valid && last_lvl;
  assign busy      = (state_q != ST_IDLE);
  assign err_path  = err_q;

  oram_bucket_ram #(
    .W     (BW),
    .DEPTH (NODES),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_oram_bucket_server.sv
// Bench for oram_bucket_server: table of write/read cases, hand-built corner
// sequences and a randomized phase checked against an array model of the tree.
module tb_oram_bucket_server;

  localparam int A     = 8;
  localparam int D     = 6;
  localparam int K     = 3;
  localparam int TW    = 2 * D + 8 * A;
  localparam int BW    = K * TW;
  localparam int NODES = (1 << D) - 1;
  localparam int LW    = $clog2(D);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [D-2:0]  cmd_leaf = '0;
  logic          cmd_ready, rd_valid, rd_last, wr_ready, busy, err_path;
  logic          rd_ready = 1'b0, wr_valid = 1'b0;
  logic [BW-1:0] rd_bucket, wr_bucket = '0;
  logic [LW-1:0] rd_level;

  int n_vec = 0;
  int n_bad = 0;

  logic [BW-1:0] mem_m  [NODES];
  logic [BW-1:0] wr_path [D];
  logic [BW-1:0] rd_cap  [D];

  typedef struct {
    int           wr_leaf;
    int           lvl;
    int           slot;
    logic [D-2:0] pos;
    logic [D-1:0] bnum;
    logic [63:0]  val;
    int           rd_leaf;
    bit           exp_vis;
    int           exp_err;
  } vec_t;

  vec_t tbl [9];

  oram_bucket_server dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_leaf  (cmd_leaf),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_bucket (rd_bucket),
    .rd_level  (rd_level),
    .rd_last   (rd_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_bucket (wr_bucket),
    .busy      (busy),
    .err_path  (err_path)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got timeout want event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Heap index at level l: 2^l plus the first l leaf bits read as a bit-reversed number.
  function automatic int model_addr(input int lvl, input int leaf);
    int n;
    n = 1 << lvl;
    for (int i = 0; i < lvl; i++) if (leaf[i]) n += 1 << (lvl - 1 - i);
    return n - 1;
  endfunction

  function automatic int model_errs(input int leaf);
    int cnt;
    cnt = 0;
    for (int l = 1; l < D; l++) begin
      bit bad;
      bad = 1'b0;
      for (int s = 0; s < K; s++) begin
        int p;
        p = int'(wr_path[l][s*TW + 8*A + D +: D-1]);
        if (wr_path[l][s*TW + TW - 1] && ((p % (1 << l)) != (leaf % (1 << l)))) bad = 1'b1;
      end
      if (bad) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [TW-1:0] mk_tuple(input logic [D-2:0] pos, input logic [D-1:0] bnum,
                                             input logic [63:0] val);
    return {1'b1, pos, bnum, val};
  endfunction

  task automatic do_reset();
    int cnt;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_err_path", err_path, 0);
    check("rst_rd_bucket", rd_bucket, 0);
    check("rst_rd_level", rd_level, 0);
    check("rst_busy", busy, 1);
    for (int i = 0; i < NODES; i++) mem_m[i] = '0;
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    while (!cmd_ready && cnt < 200) begin
      step();
      cnt++;
    end
    check("init_cycles", cnt, NODES);
    check("idle_not_busy", busy, 0);
  endtask

  task automatic read_path(input int leaf, input bit rnd);
    int got, cyc;
    bit seen;
    got = 0;
    cyc = 0;
    seen = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_leaf = (D-1)'(leaf);
    check("rd_cmd_ready", cmd_ready, 1);
    rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    cyc = 1;
    cmd_valid = 1'b0;
    check("rd_no_early_valid", rd_valid, 0);
    while (got < D && cyc < 200) begin
      check("rd_no_wr_ready", wr_ready, 0);
      if (rd_valid) begin
        if (!seen) begin
          check("rd_first_latency", cyc, 2);
          seen = 1'b1;
        end
        check("rd_level", rd_level, got);
        check("rd_last", rd_last, got == D - 1);
        check("rd_bucket", rd_bucket, mem_m[model_addr(got, leaf)]);
        if (rd_ready) begin
          rd_cap[got] = rd_bucket;
          got++;
        end
      end
      step();
      cyc++;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rd_ready = 1'b0;
    if (got < D) fail("rd_timeout");
    check("rd_done_cmd_ready", cmd_ready, 1);
    if (!rnd) check("rd_path_cycles", cyc, 2 * D + 1);
  endtask

  task automatic write_path(input int leaf, input bit gaps, output int errs);
    int lvl, cyc;
    lvl = 0;
    cyc = 0;
    errs = 0;
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    cmd_leaf = (D-1)'(leaf);
    check("wr_cmd_ready", cmd_ready, 1);
    step();
    cyc = 1;
    cmd_valid = 1'b0;
    wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_bucket = wr_path[0];
    while (lvl < D && cyc < 200) begin
      check("wr_no_rd_valid", rd_valid, 0);
      if (err_path) errs++;
      if (wr_ready && wr_valid) begin
        mem_m[model_addr(lvl, leaf)] = wr_path[lvl];
        lvl++;
      end
      step();
      cyc++;
      wr_valid = (lvl < D) && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      wr_bucket = wr_path[(lvl < D) ? lvl : D - 1];
    end
    wr_valid = 1'b0;
    if (lvl < D) fail("wr_timeout");
    if (err_path) errs++;
    check("wr_done_cmd_ready", cmd_ready, 1);
    if (!gaps) check("wr_path_cycles", cyc, D + 1);
    step();
    check("wr_err_settled", err_path, 0);
  endtask

  initial begin
    int errs, exp, hs, cyc, leaf;

    tbl[0] = '{5,  3, 0, 5'd5,  6'd9,  64'hDEADBEEF_00000001, 5,  1'b1, 0};
    tbl[1] = '{5,  3, 0, 5'd5,  6'd9,  64'hDEADBEEF_00000001, 21, 1'b1, 0};
    tbl[2] = '{5,  3, 0, 5'd5,  6'd9,  64'hDEADBEEF_00000001, 4,  1'b0, 0};
    tbl[3] = '{0,  2, 1, 5'd3,  6'd7,  64'h0123456789ABCDEF,  0,  1'b1, 1};
    tbl[4] = '{31, 5, 2, 5'd31, 6'd63, 64'hFFFFFFFFFFFFFFFF,  31, 1'b1, 0};
    tbl[5] = '{31, 5, 2, 5'd30, 6'd1,  64'h00000000000000AA,  31, 1'b1, 1};
    tbl[6] = '{12, 0, 1, 5'd19, 6'd33, 64'h5555AAAA5555AAAA,  7,  1'b1, 0};
    tbl[7] = '{9,  4, 0, 5'd25, 6'd12, 64'hCAFEF00D12345678,  25, 1'b1, 0};
    tbl[8] = '{9,  4, 0, 5'd25, 6'd12, 64'hCAFEF00D12345678,  1,  1'b0, 0};

    #2;
    do_reset();

    read_path(0, 1'b0);
    for (int l = 0; l < D; l++) check("fresh_leaf0_empty", rd_cap[l], 0);

    for (int i = 0; i < 9; i++) begin
      for (int l = 0; l < D; l++) wr_path[l] = '0;
      wr_path[tbl[i].lvl][tbl[i].slot*TW +: TW] = mk_tuple(tbl[i].pos, tbl[i].bnum, tbl[i].val);
      write_path(tbl[i].wr_leaf, 1'b0, errs);
      check("tbl_err_pulses", errs, tbl[i].exp_err);
      read_path(tbl[i].rd_leaf, 1'b0);
      if (tbl[i].exp_vis)
        check("tbl_tuple", rd_cap[tbl[i].lvl][tbl[i].slot*TW +: TW],
              mk_tuple(tbl[i].pos, tbl[i].bnum, tbl[i].val));
      else
        check("tbl_empty", rd_cap[tbl[i].lvl][tbl[i].slot*TW + TW - 1], 0);
    end

    // Two violating tuples in one bucket must give a single pulse.
    for (int l = 0; l < D; l++) wr_path[l] = '0;
    wr_path[3][0*TW +: TW] = mk_tuple(5'd7, 6'd2, 64'h1111);
    wr_path[3][1*TW +: TW] = mk_tuple(5'd5, 6'd3, 64'h2222);
    wr_path[3][2*TW +: TW] = mk_tuple(5'd0, 6'd4, 64'h3333);
    write_path(0, 1'b1, errs);
    check("multi_bad_one_pulse", errs, 1);
    read_path(0, 1'b1);

    read_path(5, 1'b1);

    for (int it = 0; it < 40; it++) begin
      leaf = int'($urandom_range(0, (1 << (D - 1)) - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int l = 0; l < D; l++) begin
          wr_path[l] = '0;
          for (int s = 0; s < K; s++) begin
            if ($urandom_range(0, 2) != 0) begin
              logic [D-2:0] p;
              p = ($urandom_range(0, 3) == 0) ? (D-1)'($urandom) : (D-1)'(leaf);
              wr_path[l][s*TW +: TW] = mk_tuple(p, D'($urandom), {$urandom, $urandom});
            end
          end
        end
        exp = model_errs(leaf);
        write_path(leaf, 1'($urandom_range(0, 1)), errs);
        check("rand_err_pulses", errs, exp);
      end else begin
        read_path(leaf, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of a read, after the third handshake.
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_leaf = 5'd5;
    step();
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    hs = 0;
    cyc = 0;
    while (hs < 3 && cyc < 50) begin
      if (rd_valid) hs++;
      step();
      cyc++;
    end
    if (hs < 3) fail("mid_read_timeout");
    do_reset();
    read_path(5, 1'b0);
    check("post_reset_lvl3_empty", rd_cap[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
